// File: rtl/lab3_pkg.sv
// lab3_pkg: shared FSM state encoding and width helper
package lab3_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FULL  = 2'b10
  } state_t;
  function automatic int bc_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/sync_chain.sv
// sync_chain: reset-to-zero flop chain synchronising a single bit
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  always_comb begin
    chain_d    = chain_q << 1;
    chain_d[0] = d;
  end
  always_ff @(posedge Clk) begin
    if (!Resetn) chain_q <= '0;
    else         chain_q <= chain_d;
  end
  assign q = chain_q[SYNC_STAGES-1];
endmodule

// File: rtl/latch_shift_capture.sv
// latch_shift_capture: synchronise latched bit, shift WIDTH samples into a word, Valid/Ack handoff
module latch_shift_capture
  import lab3_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     Clk,
  input  logic                     Resetn,
  input  logic                     Q_in,
  input  logic                     Start,
  input  logic                     Ack,
  output logic [WIDTH-1:0]         Data,
  output logic                     Valid,
  output logic                     Busy,
  output logic [bc_w(WIDTH)-1:0]   BitCount,
  output logic                     Overrun
);
  localparam int CW = bc_w(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, data_q, data_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d, busy_q, busy_d, ovr_q, ovr_d, s;
  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .Clk    (Clk),
    .Resetn (Resetn),
    .d      (Q_in),
    .q      (s)
  );
  assign shifted = {shreg_q[WIDTH-2:0], s};
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d = SHIFT;
        cnt_d   = '0;
        busy_d  = 1'b1;
        shreg_d = '0;
      end
      SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          data_d  = shifted;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = FULL;
        end
      end
      FULL: begin
        // Ack takes priority over a simultaneous Start; Start is never queued
        if (Ack) begin
          valid_d = 1'b0;
          ovr_d   = 1'b0;
          state_d = IDLE;
        end else if (Start) ovr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end
  assign Data     = data_q;
  assign Valid    = valid_q;
  assign Busy     = busy_q;
  assign BitCount = cnt_q;
  assign Overrun  = ovr_q;
endmodule

// File: tb/tb_latch_shift_capture.sv
// tb_latch_shift_capture: directed self-checking bench for latch_shift_capture
module tb_latch_shift_capture;
  logic       Clk = 1'b0, Resetn = 1'b1, Q_in = 1'b0, Start = 1'b0, Ack = 1'b0;
  logic [7:0] Data;
  logic       Valid, Busy, Overrun;
  logic [3:0] BitCount;
  int         n_chk = 0, n_fail = 0;
  latch_shift_capture #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .Clk      (Clk),
    .Resetn   (Resetn),
    .Q_in     (Q_in),
    .Start    (Start),
    .Ack      (Ack),
    .Data     (Data),
    .Valid    (Valid),
    .Busy     (Busy),
    .BitCount (BitCount),
    .Overrun  (Overrun)
  );
  always #5 Clk = ~Clk;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  // Iteration m lands on edge t0+m-2; Q_in leads s by two edges so s=w[7] at t0+1
  task automatic run_word(input logic [7:0] w, input logic mid_start);
    for (int m = 1; m <= 10; m++) begin
      Q_in  = (m <= 8) ? w[8-m] : 1'b0;
      Start = (m == 2) || (mid_start && (m == 5 || m == 7));
      tick();
    end
    Start = 1'b0;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 20; i++) begin
      Q_in  = 1'($urandom);
      Start = 1'($urandom);
      Ack   = 1'($urandom);
      tick();
    end
    Resetn = 1'b0;
    tick();
    tick();
    n_chk += 5;
    if (Data !== 8'h00)    begin n_fail++; $display("FAIL reset_data got %h want 00", Data); end
    if (Valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got %b want 0", Valid); end
    if (Busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", Busy); end
    if (BitCount !== 4'd0) begin n_fail++; $display("FAIL reset_bitcount got %0d want 0", BitCount); end
    if (Overrun !== 1'b0)  begin n_fail++; $display("FAIL reset_overrun got %b want 0", Overrun); end
    Resetn = 1'b1;
    Start  = 1'b0;
    Ack    = 1'b0;
    tick();
  endtask
  task automatic test_capture();
    logic [7:0] w;
    w = 8'hA5;
    for (int m = 1; m <= 10; m++) begin
      Q_in  = (m <= 8) ? w[8-m] : 1'b0;
      Start = (m == 2);
      tick();
      n_chk += 2;
      if (Busy !== (m >= 2 && m <= 9)) begin n_fail++; $display("FAIL cap_busy step %0d got %b want %b", m, Busy, (m >= 2 && m <= 9)); end
      if (Valid !== (m == 10))         begin n_fail++; $display("FAIL cap_valid step %0d got %b want %b", m, Valid, (m == 10)); end
    end
    Start = 1'b0;
    n_chk += 2;
    if (Data !== 8'hA5)    begin n_fail++; $display("FAIL cap_data got %h want a5", Data); end
    if (BitCount !== 4'd8) begin n_fail++; $display("FAIL cap_bitcount got %0d want 8", BitCount); end
  endtask
  task automatic test_hold_ack();
    for (int i = 0; i < 6; i++) begin
      Q_in = 1'($urandom);
      tick();
      n_chk += 2;
      if (Data !== 8'hA5) begin n_fail++; $display("FAIL hold_data cyc %0d got %h want a5", i, Data); end
      if (Valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid cyc %0d got %b want 1", i, Valid); end
    end
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    n_chk += 3;
    if (Valid !== 1'b0) begin n_fail++; $display("FAIL ack_valid got %b want 0", Valid); end
    if (Busy !== 1'b0)  begin n_fail++; $display("FAIL ack_busy got %b want 0", Busy); end
    if (Data !== 8'hA5) begin n_fail++; $display("FAIL ack_data got %h want a5", Data); end
    tick();
    n_chk++;
    if (Busy !== 1'b0)  begin n_fail++; $display("FAIL idle_busy got %b want 0", Busy); end
  endtask
  task automatic test_overrun();
    run_word(8'h5A, 1'b1);
    n_chk += 3;
    if (Data !== 8'h5A)    begin n_fail++; $display("FAIL mid_start_data got %h want 5a", Data); end
    if (BitCount !== 4'd8) begin n_fail++; $display("FAIL mid_start_bitcount got %0d want 8", BitCount); end
    if (Valid !== 1'b1)    begin n_fail++; $display("FAIL mid_start_valid got %b want 1", Valid); end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    n_chk += 3;
    if (Overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b want 1", Overrun); end
    if (Data !== 8'h5A)   begin n_fail++; $display("FAIL ovr_data got %h want 5a", Data); end
    if (Valid !== 1'b1)   begin n_fail++; $display("FAIL ovr_valid got %b want 1", Valid); end
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    n_chk += 2;
    if (Overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", Overrun); end
    if (Valid !== 1'b0)   begin n_fail++; $display("FAIL ovr_ack_valid got %b want 0", Valid); end
  endtask
  task automatic test_abort();
    for (int m = 1; m <= 5; m++) begin
      Q_in  = 1'b1;
      Start = (m == 2);
      tick();
    end
    Start = 1'b0;
    n_chk++;
    if (BitCount !== 4'd3) begin n_fail++; $display("FAIL abort_pre_bitcount got %0d want 3", BitCount); end
    Resetn = 1'b0;
    tick();
    n_chk += 4;
    if (Busy !== 1'b0)     begin n_fail++; $display("FAIL abort_busy got %b want 0", Busy); end
    if (BitCount !== 4'd0) begin n_fail++; $display("FAIL abort_bitcount got %0d want 0", BitCount); end
    if (Valid !== 1'b0)    begin n_fail++; $display("FAIL abort_valid got %b want 0", Valid); end
    if (Data !== 8'h00)    begin n_fail++; $display("FAIL abort_data got %h want 00", Data); end
    Resetn = 1'b1;
    run_word(8'h3C, 1'b0);
    n_chk += 2;
    if (Data !== 8'h3C) begin n_fail++; $display("FAIL recap_data got %h want 3c", Data); end
    if (Valid !== 1'b1) begin n_fail++; $display("FAIL recap_valid got %b want 1", Valid); end
  endtask
  task automatic test_start_ack();
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    run_word(8'h96, 1'b0);
    Start = 1'b1;
    tick();
    n_chk++;
    if (Overrun !== 1'b1) begin n_fail++; $display("FAIL sa_pre_ovr got %b want 1", Overrun); end
    Ack = 1'b1;
    tick();
    Start = 1'b0;
    Ack   = 1'b0;
    n_chk += 3;
    if (Valid !== 1'b0)   begin n_fail++; $display("FAIL sa_valid got %b want 0", Valid); end
    if (Overrun !== 1'b0) begin n_fail++; $display("FAIL sa_ovr got %b want 0", Overrun); end
    if (Busy !== 1'b0)    begin n_fail++; $display("FAIL sa_busy got %b want 0", Busy); end
    tick();
    n_chk += 3;
    if (Busy !== 1'b0)  begin n_fail++; $display("FAIL sa_next_busy got %b want 0", Busy); end
    if (Valid !== 1'b0) begin n_fail++; $display("FAIL sa_next_valid got %b want 0", Valid); end
    if (Data !== 8'h96) begin n_fail++; $display("FAIL sa_data got %h want 96", Data); end
  endtask
  initial begin
    test_reset();
    test_capture();
    test_hold_ack();
    test_overrun();
    test_abort();
    test_start_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
